// File: rtl/spin_readout_pkg.sv
// Shared address map, register word offsets and FSM state type for the spin readout block.
package spin_readout_pkg;

    localparam logic [7:0] WEIGHT_ADDR_MASK  = 8'hA0;
    localparam logic [7:0] READOUT_ADDR_MASK = 8'hA1;

    // Word offsets (byte address [11:2])
    localparam logic [9:0] RO_CTRL   = 10'h000;
    localparam logic [9:0] RO_STATUS = 10'h001;
    localparam logic [9:0] RO_ANNEAL = 10'h002;
    localparam logic [9:0] RO_SPIN   = 10'h004;
    localparam logic [9:0] RO_CNT    = 10'h040;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ANNEAL,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    function automatic logic ro_selected(input logic [31:0] addr);
        return addr[31:24] == READOUT_ADDR_MASK;
    endfunction

endpackage

// File: rtl/spin_readout_osc_sync.sv
// Multi-flop synchroniser bringing one asynchronous oscillator output into the clk domain.
module osc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_p0;

    always_ff @(posedge clk) begin
        ff_p0 <= {ff_p0[STAGES-2:0], d};
    end

    assign q = ff_p0[STAGES-1];

endmodule

// File: rtl/spin_readout.sv
// Anneal run controller and phase-agreement spin readout, with a small register port for control and status.
module spin_readout
    import spin_readout_pkg::*;
#(
    parameter int          N              = 8,
    parameter int          WINDOW         = 1024,
    parameter int          SYNC_STAGES    = 2,
    parameter logic [31:0] DEFAULT_ANNEAL = 32'd4096
) (
    input  logic          clk,
    input  logic          axi_rst,
    input  logic [N-1:0]  osc,
    output logic          ising_rstn,
    input  logic          wready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rdata
);

    localparam int CNT_W      = $clog2(WINDOW + 1);
    localparam int SCNT_W     = $clog2(WINDOW);
    localparam int SPIN_WORDS = (N + 31) / 32;

    logic [N-1:0]        s;
    logic [N-1:0]        agree;
    state_t              state, state_next;
    logic [31:0]         anneal_reg;
    logic [31:0]         acnt;
    logic [SCNT_W-1:0]   scnt;
    logic [CNT_W-1:0]    cnt [N];
    logic [N-1:0]        spin;
    logic                busy, done;
    logic                wr_sel, start, abort, run_start, sample_last;
    logic [9:0]          wr_word, rd_word;
    logic [32*SPIN_WORDS-1:0] spin_pad;
    logic                unused_addr_bits;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_sync
            osc_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .d(osc[g]), .q(s[g]));
        end
    endgenerate

    assign agree = s ~^ {N{s[0]}};

    assign wr_sel  = wready && ro_selected(wr_addr);
    assign wr_word = wr_addr[11:2];
    assign rd_word = rd_addr[11:2];
    assign abort   = wr_sel && (wr_word == RO_CTRL) && wdata[1];
    assign start   = wr_sel && (wr_word == RO_CTRL) && wdata[0] && !wdata[1];
    assign run_start   = start && (state == ST_IDLE || state == ST_DONE);
    assign sample_last = (state == ST_SAMPLE) && (scnt == SCNT_W'(WINDOW - 1));
    assign unused_addr_bits = ^{wr_addr[23:12], wr_addr[1:0], rd_addr[23:12], rd_addr[1:0]};

    always_ff @(posedge clk) begin
        if (axi_rst) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start)       state_next = ST_ANNEAL;
                ST_ANNEAL:        if (acnt == '0)  state_next = ST_SAMPLE;
                ST_SAMPLE:        if (sample_last) state_next = ST_DONE;
                default:                           state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ising_rstn = (state != ST_IDLE);
        busy       = (state == ST_ANNEAL) || (state == ST_SAMPLE);
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (axi_rst) anneal_reg <= DEFAULT_ANNEAL;
        else if (wr_sel && wr_word == RO_ANNEAL) anneal_reg <= wdata;
    end

    // ANNEAL is latched at start so mid-run writes only affect the next run
    always_ff @(posedge clk) begin
        if (run_start)                             acnt <= anneal_reg;
        else if (state == ST_ANNEAL && acnt != '0) acnt <= acnt - 32'd1;
        if (state == ST_SAMPLE) scnt <= scnt + SCNT_W'(1);
        else                    scnt <= '0;
    end

    generate
        for (g = 0; g < N; g++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (axi_rst)                 cnt[g] <= '0;
                else if (run_start)          cnt[g] <= '0;
                else if (state == ST_SAMPLE) cnt[g] <= cnt[g] + CNT_W'(agree[g]);
            end

            // The final sample is folded in so spin is valid on the first DONE cycle
            always_ff @(posedge clk) begin
                if (axi_rst)
                    spin[g] <= 1'b0;
                else if (sample_last && !abort)
                    spin[g] <= (cnt[g] + CNT_W'(agree[g])) > CNT_W'(WINDOW / 2);
            end
        end
    endgenerate

    assign spin_pad = (32*SPIN_WORDS)'(spin);

    always_comb begin
        rdata = '0;
        if (ro_selected(rd_addr)) begin
            if (rd_word == RO_STATUS) rdata = {30'b0, done, busy};
            if (rd_word == RO_ANNEAL) rdata = anneal_reg;
            for (int w = 0; w < SPIN_WORDS; w++) begin
                if (rd_word == 10'(int'(RO_SPIN) + w)) rdata = spin_pad[32*w +: 32];
            end
            for (int i = 0; i < N; i++) begin
                if (rd_word == 10'(int'(RO_CNT) + i)) rdata = 32'(cnt[i]);
            end
        end
    end

endmodule
